// File: rtl/ddr2_cmd_crc_checker.sv
// CRC-8 checker for host commands: validates {cmd,sz,addr}, buffers good commands toward the
// controller, drops bad ones, and throttles the host with a hold-off and a retry limit.
module ddr2_cmd_crc_checker #(
    parameter int ADDR_WIDTH  = 25,
    parameter int FIFO_DEPTH  = 4,
    parameter int HOLD_CYCLES = 8,
    parameter int MAX_RETRY   = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            in_cmd,
    input  logic [1:0]            in_sz,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [7:0]            in_crc,
    input  logic                  in_put,
    output logic                  in_ready,
    output logic                  crc_ok,
    output logic                  crc_error,
    output logic [ADDR_WIDTH-1:0] err_addr,
    output logic [15:0]           err_cnt,
    output logic                  fault,
    output logic [2:0]            ctrl_cmd,
    output logic [1:0]            ctrl_sz,
    output logic [ADDR_WIDTH-1:0] ctrl_addr,
    output logic                  ctrl_cmd_put,
    input  logic                  ctrl_full
);
    localparam int MSG_W = ADDR_WIDTH + 5;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMR_W = $clog2(HOLD_CYCLES + 1);
    localparam int RTY_W = $clog2(MAX_RETRY + 1);

    typedef enum logic [1:0] {ST_RUN, ST_HOLD, ST_FAULT} state_t;

    // Serial CRC-8, poly 0x07, init 0, MSB first, no reflection, no final XOR.
    function automatic logic [7:0] crc8(input logic [MSG_W-1:0] msg);
        logic [7:0] crc;
        crc = 8'h00;
        for (int i = MSG_W - 1; i >= 0; i--) begin
            crc = {crc[6:0], 1'b0} ^ ((crc[7] ^ msg[i]) ? 8'h07 : 8'h00);
        end
        return crc;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t                  state_q, state_d;
    logic [TMR_W-1:0]        timer_q, timer_d;
    logic [RTY_W-1:0]        retry_q, retry_d;
    logic                    s1_vld_q, s1_vld_d;
    logic [MSG_W-1:0]        s1_msg_q, s1_msg_d;
    logic [7:0]              s1_crc_q, s1_crc_d;
    logic                    crc_ok_q, crc_ok_d;
    logic                    crc_error_q, crc_error_d;
    logic [ADDR_WIDTH-1:0]   err_addr_q, err_addr_d;
    logic [15:0]             err_cnt_q, err_cnt_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [MSG_W-1:0]        hold_q, hold_d;
    logic [MSG_W-1:0]        mem_q [FIFO_DEPTH];
    logic [MSG_W-1:0]        mem_d [FIFO_DEPTH];

    logic                    accept, eval, good, bad, push, pop, fifo_empty;
    logic [7:0]              calc_crc;
    logic [CNT_W:0]          occupancy;
    logic [MSG_W-1:0]        head;

    // Stage-1 entry reserves a FIFO slot so an accepted command can always land.
    assign occupancy  = {1'b0, count_q} + {{CNT_W{1'b0}}, s1_vld_q};
    assign in_ready   = reset && (state_q == ST_RUN) && (occupancy < (CNT_W + 1)'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign ctrl_cmd_put = !fifo_empty && !ctrl_full;
    assign head       = fifo_empty ? hold_q : mem_q[rd_ptr_q];
    assign ctrl_cmd   = head[MSG_W-1 -: 3];
    assign ctrl_sz    = head[MSG_W-4 -: 2];
    assign ctrl_addr  = head[ADDR_WIDTH-1:0];
    assign crc_ok     = crc_ok_q;
    assign crc_error  = crc_error_q;
    assign err_addr   = err_addr_q;
    assign err_cnt    = err_cnt_q;
    assign fault      = (state_q == ST_FAULT);

    // Stage 1 capture and stage 2 check; a registered error squashes whatever sits in stage 1.
    always_comb begin
        accept   = in_put && in_ready;
        s1_vld_d = accept;
        s1_msg_d = accept ? {in_cmd, in_sz, in_addr} : s1_msg_q;
        s1_crc_d = accept ? in_crc : s1_crc_q;

        calc_crc = crc8(s1_msg_q);
        eval     = s1_vld_q && !crc_error_q && (state_q != ST_FAULT);
        good     = eval && (calc_crc == s1_crc_q);
        bad      = eval && (calc_crc != s1_crc_q);

        crc_ok_d    = good;
        crc_error_d = bad;
        err_addr_d  = bad ? s1_msg_q[ADDR_WIDTH-1:0] : err_addr_q;
        err_cnt_d   = bad ? sat_inc16(err_cnt_q) : err_cnt_q;
    end

    // Good-command FIFO; the output holds the last popped head while empty.
    always_comb begin
        push     = good;
        pop      = ctrl_cmd_put;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        hold_d   = hold_q;
        if (push) begin
            mem_d[wr_ptr_q] = s1_msg_q;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            hold_d   = mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        retry_d = retry_q;
        case (state_q)
            ST_RUN: begin
                if (bad) begin
                    retry_d = retry_q + RTY_W'(1);
                    if ((retry_q + RTY_W'(1)) == RTY_W'(MAX_RETRY)) begin
                        state_d = ST_FAULT;
                    end else begin
                        state_d = ST_HOLD;
                        timer_d = TMR_W'(HOLD_CYCLES);
                    end
                end else if (good) begin
                    retry_d = '0;
                end
            end
            ST_HOLD: begin
                if (timer_q <= TMR_W'(1)) begin
                    state_d = ST_RUN;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_RUN;
            timer_q     <= '0;
            retry_q     <= '0;
            s1_vld_q    <= 1'b0;
            crc_ok_q    <= 1'b0;
            crc_error_q <= 1'b0;
            err_addr_q  <= '0;
            err_cnt_q   <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            hold_q      <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            retry_q     <= retry_d;
            s1_vld_q    <= s1_vld_d;
            crc_ok_q    <= crc_ok_d;
            crc_error_q <= crc_error_d;
            err_addr_q  <= err_addr_d;
            err_cnt_q   <= err_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            hold_q      <= hold_d;
        end
    end

    // Payload storage carries no reset; validity lives in the control flops above.
    always_ff @(posedge clk) begin
        s1_msg_q <= s1_msg_d;
        s1_crc_q <= s1_crc_d;
        mem_q    <= mem_d;
    end

endmodule

// File: tb/tb_ddr2_cmd_crc_checker.sv
// Directed bench for ddr2_cmd_crc_checker: a queue-based reference model checked every cycle,
// plus literal expectations for the key scenarios.
module tb_ddr2_cmd_crc_checker;
    localparam int AW    = 25;
    localparam int DEPTH = 4;
    localparam int HOLD  = 8;
    localparam int MAXR  = 3;

    logic          clk, reset;
    logic [2:0]    in_cmd;
    logic [1:0]    in_sz;
    logic [AW-1:0] in_addr;
    logic [7:0]    in_crc;
    logic          in_put, in_ready, crc_ok, crc_error, fault;
    logic [AW-1:0] err_addr, ctrl_addr;
    logic [15:0]   err_cnt;
    logic [2:0]    ctrl_cmd;
    logic [1:0]    ctrl_sz;
    logic          ctrl_cmd_put, ctrl_full;

    int n_vec = 0;
    int n_bad = 0;

    ddr2_cmd_crc_checker #(.ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH), .HOLD_CYCLES(HOLD), .MAX_RETRY(MAXR)) dut (
        .clk(clk), .reset(reset), .in_cmd(in_cmd), .in_sz(in_sz), .in_addr(in_addr), .in_crc(in_crc),
        .in_put(in_put), .in_ready(in_ready), .crc_ok(crc_ok), .crc_error(crc_error),
        .err_addr(err_addr), .err_cnt(err_cnt), .fault(fault), .ctrl_cmd(ctrl_cmd), .ctrl_sz(ctrl_sz),
        .ctrl_addr(ctrl_addr), .ctrl_cmd_put(ctrl_cmd_put), .ctrl_full(ctrl_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // CRC as polynomial remainder of M(x)*x^8 modulo x^8+x^2+x+1.
    function automatic logic [7:0] ref_crc(input logic [29:0] m);
        logic [37:0] r;
        r = {m, 8'h00};
        for (int i = 37; i >= 8; i--) begin
            if (r[i]) r[i -: 9] = r[i -: 9] ^ 9'h107;
        end
        return r[7:0];
    endfunction

    function automatic logic [7:0] good_crc(input logic [2:0] c, input logic [1:0] s, input logic [AW-1:0] a);
        return ref_crc({c, s, a});
    endfunction

    // Reference model state
    bit            m_live = 0;
    bit            slot_v = 0;
    logic [29:0]   slot_m;
    logic [7:0]    slot_c;
    logic [29:0]   q[$];
    logic [29:0]   last = '0;
    bit            m_ok = 0, m_err = 0, m_fault = 0;
    logic [AW-1:0] m_eaddr = '0;
    int            m_ecnt = 0, streak = 0;
    longint        cyc = 0, hold_end = 0;

    function automatic bit exp_ready();
        return (reset === 1'b1) && !m_fault && (cyc >= hold_end) && ((q.size() + int'(slot_v)) < DEPTH);
    endfunction

    always @(posedge clk) begin : model
        bit rdy, ev, good, bad;
        if (reset !== 1'b1) begin
            m_live = 1; slot_v = 0; q.delete(); last = '0; m_ok = 0; m_err = 0; m_fault = 0;
            m_eaddr = '0; m_ecnt = 0; streak = 0; hold_end = 0;
        end else if (m_live) begin
            rdy  = exp_ready();
            ev   = slot_v && !m_err && !m_fault;
            good = ev && (ref_crc(slot_m) == slot_c);
            bad  = ev && !good;
            if (q.size() > 0 && !ctrl_full) begin
                last = q[0];
                void'(q.pop_front());
            end
            if (good) begin
                q.push_back(slot_m);
                streak = 0;
            end
            if (bad) begin
                m_eaddr = slot_m[AW-1:0];
                if (m_ecnt < 65535) m_ecnt++;
                streak++;
                if (streak >= MAXR) m_fault = 1;
                else hold_end = cyc + 1 + HOLD;
            end
            m_ok   = good;
            m_err  = bad;
            slot_v = in_put && rdy;
            if (slot_v) begin
                slot_m = {in_cmd, in_sz, in_addr};
                slot_c = in_crc;
            end
        end
        cyc++;
    end

    // Every-cycle comparison against the model, plus event logs for the directed checks.
    int          tot_ok = 0, tot_err = 0;
    logic [AW-1:0] put_log[$];

    always @(negedge clk) begin : compare
        logic [29:0] hd;
        if (m_live) begin
            hd = (q.size() > 0) ? q[0] : last;
            chk("in_ready", 32'(in_ready), 32'(exp_ready()));
            chk("crc_ok", 32'(crc_ok), 32'(m_ok));
            chk("crc_error", 32'(crc_error), 32'(m_err));
            chk("err_addr", 32'(err_addr), 32'(m_eaddr));
            chk("err_cnt", 32'(err_cnt), 32'(m_ecnt));
            chk("fault", 32'(fault), 32'(m_fault));
            chk("ctrl_cmd_put", 32'(ctrl_cmd_put), 32'(q.size() > 0 && !ctrl_full));
            chk("ctrl_head", {2'b0, ctrl_cmd, ctrl_sz, ctrl_addr}, {2'b0, hd});
            if (crc_ok) tot_ok++;
            if (crc_error) tot_err++;
            if (ctrl_cmd_put) put_log.push_back(ctrl_addr);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic [2:0] c, input logic [1:0] s, input logic [AW-1:0] a, input logic [7:0] k);
        in_put = 1'b1; in_cmd = c; in_sz = s; in_addr = a; in_crc = k;
    endtask

    task automatic send(input logic [2:0] c, input logic [1:0] s, input logic [AW-1:0] a, input logic [7:0] k);
        drive(c, s, a, k);
        tick();
        in_put = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got no finish, expected end of run");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int ok0, err0, ps, n;
        reset = 1'b0; in_put = 1'b1; in_cmd = 3'b111; in_sz = 2'b11; in_addr = '1; in_crc = 8'h00;
        ctrl_full = 1'b0;
        repeat (3) tick();
        #3;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_crc_ok", 32'(crc_ok), 32'd0);
        chk("rst_crc_error", 32'(crc_error), 32'd0);
        chk("rst_put", 32'(ctrl_cmd_put), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        tick();
        reset = 1'b1; in_put = 1'b0;

        chk("pin_crc_0", 32'(ref_crc(30'h0)), 32'h00);
        chk("pin_crc_1", 32'(ref_crc(30'h1)), 32'h07);
        chk("pin_crc_2", 32'(ref_crc(30'h2)), 32'h0E);
        chk("pin_crc_80", 32'(ref_crc(30'h80)), 32'h89);
        chk("pin_crc_100", 32'(ref_crc(30'h100)), 32'h15);

        // Good command
        tick();
        send(3'b001, 2'b10, 25'h0123456, good_crc(3'b001, 2'b10, 25'h0123456));
        tick(); #3;
        chk("good_ok", 32'(crc_ok), 32'd1);
        chk("good_put", 32'(ctrl_cmd_put), 32'd1);
        chk("good_addr", 32'(ctrl_addr), 32'h0123456);
        chk("good_cmd", 32'(ctrl_cmd), 32'd1);
        chk("good_sz", 32'(ctrl_sz), 32'd2);

        // Bad command and hold-off length
        tick();
        send(3'b001, 2'b10, 25'h0123456, good_crc(3'b001, 2'b10, 25'h0123456) ^ 8'h01);
        tick(); #3;
        chk("bad_err", 32'(crc_error), 32'd1);
        chk("bad_ok", 32'(crc_ok), 32'd0);
        chk("bad_put", 32'(ctrl_cmd_put), 32'd0);
        chk("bad_err_addr", 32'(err_addr), 32'h0123456);
        chk("bad_err_cnt", 32'(err_cnt), 32'd1);
        n = 0;
        while (in_ready == 1'b0 && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("hold_len", 32'(n), 32'd8);

        // Literal CRC vectors through the DUT
        tick();
        send(3'b000, 2'b00, 25'h1, 8'h07);
        tick(); #3;
        chk("lit_crc_07", 32'(crc_ok), 32'd1);
        tick();
        send(3'b000, 2'b00, 25'h80, 8'h89);
        tick(); #3;
        chk("lit_crc_89", 32'(crc_ok), 32'd1);

        // Squash: A good, B bad, C good back to back
        tick();
        ok0 = tot_ok; err0 = tot_err; ps = put_log.size();
        drive(3'b010, 2'b01, 25'h0AAAAAA, good_crc(3'b010, 2'b01, 25'h0AAAAAA));
        tick();
        drive(3'b011, 2'b00, 25'h0BBBBBB, good_crc(3'b011, 2'b00, 25'h0BBBBBB) ^ 8'h10);
        tick();
        drive(3'b100, 2'b11, 25'h0CCCCCC, good_crc(3'b100, 2'b11, 25'h0CCCCCC));
        tick();
        in_put = 1'b0;
        repeat (12) tick();
        chk("sq_ok_cnt", 32'(tot_ok - ok0), 32'd1);
        chk("sq_err_cnt", 32'(tot_err - err0), 32'd1);
        chk("sq_puts", 32'(put_log.size() - ps), 32'd1);
        if (put_log.size() > ps) chk("sq_put_addr", 32'(put_log[ps]), 32'h0AAAAAA);
        chk("sq_err_addr", 32'(err_addr), 32'h0BBBBBB);
        send(3'b011, 2'b00, 25'h0BBBBBB, good_crc(3'b011, 2'b00, 25'h0BBBBBB));
        repeat (4) tick();

        // Fault after consecutive errors
        pulse_reset();
        for (int r = 0; r < 3; r++) begin
            tick();
            send(3'b101, 2'b01, 25'h1000000 + 25'(r), good_crc(3'b101, 2'b01, 25'h1000000 + 25'(r)) ^ 8'h80);
            tick(); #3;
            chk("flt_fault_step", 32'(fault), 32'(r == 2));
            repeat (11) tick();
        end
        #3;
        chk("flt_fault", 32'(fault), 32'd1);
        chk("flt_err_cnt", 32'(err_cnt), 32'd3);
        chk("flt_err_addr", 32'(err_addr), 32'h1000002);
        ok0 = tot_ok;
        tick();
        send(3'b001, 2'b00, 25'h55, good_crc(3'b001, 2'b00, 25'h55));
        repeat (4) tick();
        #3;
        chk("flt_ready", 32'(in_ready), 32'd0);
        chk("flt_no_ok", 32'(tot_ok - ok0), 32'd0);

        // Backpressure: four buffered, then four consecutive puts in order
        pulse_reset();
        tick();
        ctrl_full = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(3'(i), 2'(i), 25'h100 + 25'(i), good_crc(3'(i), 2'(i), 25'h100 + 25'(i)));
            tick();
        end
        in_put = 1'b0;
        #3;
        chk("bp_ready", 32'(in_ready), 32'd0);
        chk("bp_put_blocked", 32'(ctrl_cmd_put), 32'd0);
        tick();
        ctrl_full = 1'b0;
        #3;
        for (int k = 0; k < 4; k++) begin
            chk("bp_put", 32'(ctrl_cmd_put), 32'd1);
            chk("bp_addr", 32'(ctrl_addr), 32'h100 + 32'(k));
            chk("bp_cmd", 32'(ctrl_cmd), 32'(k));
            @(negedge clk);
        end
        chk("bp_drained", 32'(ctrl_cmd_put), 32'd0);
        chk("bp_hold_head", 32'(ctrl_addr), 32'h103);

        // Refill while full, then stream while draining
        tick();
        ctrl_full = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(3'b110, 2'b01, 25'h200 + 25'(i), good_crc(3'b110, 2'b01, 25'h200 + 25'(i)));
            tick();
        end
        in_put = 1'b0;
        repeat (3) tick();
        ps = put_log.size();
        ctrl_full = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(3'b010, 2'b10, 25'h300 + 25'(i), good_crc(3'b010, 2'b10, 25'h300 + 25'(i)));
            tick();
        end
        in_put = 1'b0;
        repeat (10) tick();
        for (int i = 0; i < 4; i++) begin
            if (put_log.size() > ps + i) chk("st_order", 32'(put_log[ps + i]), 32'h200 + 32'(i));
            else chk("st_count", 32'(put_log.size() - ps), 32'd4);
        end

        // Reset mid-operation discards buffered commands
        ctrl_full = 1'b1;
        drive(3'b001, 2'b01, 25'h400, good_crc(3'b001, 2'b01, 25'h400));
        tick();
        drive(3'b001, 2'b01, 25'h401, good_crc(3'b001, 2'b01, 25'h401));
        tick();
        in_put = 1'b0;
        tick();
        ps = put_log.size();
        pulse_reset();
        ctrl_full = 1'b0;
        tick(); #3;
        chk("mr_put", 32'(ctrl_cmd_put), 32'd0);
        chk("mr_addr", 32'(ctrl_addr), 32'd0);
        chk("mr_ready", 32'(in_ready), 32'd1);
        repeat (5) tick();
        chk("mr_no_puts", 32'(put_log.size() - ps), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
